keypad_matrix_emulator: RTL and testbench
=========================================

Name: keypad_matrix_emulator

Overview:
Synthesizable responder for the 4-row x 3-column keypad scan interface. It plays the keypad side that the scanner's `out_to_keypad` and `in_from_keypad` ports connect to. It accepts "press key K for H cycles" commands over a valid/ready handshake, waits for the scanner to drive the key's row, and asserts the key's column only while that row is active. It is used for on-board loopback self-test of the keypad scanner and input manager, in place of the physical keypad.

Parameters:
HOLD_W, 20, width of the hold-duration field in clock cycles.
TIMEOUT_CYCLES, 10000, cycles to wait for the target row before aborting.
GAP_CYCLES, 1000, release interval after every command; no column is driven during it.
CNT_W, 8, width of the successful-press counter.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  reset; synchronous, active-high
in_row  input  4  row drive from the scanner (`out_to_keypad`); one-hot; 0100=row1, 0010=row2, 0001=row3, 1000=row4
out_col  output  3  column sense to the scanner (`in_from_keypad`); 3'b111 means no key; otherwise one-hot 100/010/001 = left/mid/right
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE
cmd_key  input  4  key code: 0..8 = keys 1..9, 9 = *, 10 = 0, 11 = #, 12..15 invalid
cmd_hold  input  HOLD_W  press duration in cycles
busy  output  1  state != IDLE
done  output  1  1-cycle pulse when a command fully completes
timeout  output  1  1-cycle pulse, coincident with done, when the row was never seen
err_key  output  1  1-cycle pulse, coincident with done, when the key code was invalid
press_count  output  CNT_W  count of presses that reached HOLD; wraps to 0

Behaviour:
- Reset values, effective at the first clk edge with rst=1: state=IDLE, out_col=3'b111, cmd_ready=1, busy=0, done=0, timeout=0, err_key=0, press_count=0.
- Reset mid-operation: the command is abandoned with no done pulse; out_col=111 from the next edge.
- Accept: the command is accepted on a clk edge with cmd_valid & cmd_ready. key, row, col and hold are latched at that edge. cmd_ready falls in the next cycle.
- Key map:
  - 0..2 → row 0100, cols 100/010/001
  - 3..5 → row 0010, same column order
  - 6..8 → row 0001, same column order
  - 9/10/11 → row 1000, same column order
- FSM IDLE → WAIT_ROW:
  - Taken on accept with a valid key and hold>0.
  - Invalid key: go directly to GAP with err flag set.
  - hold=0: go directly to GAP, no flags set, press_count unchanged.
- FSM WAIT_ROW:
  - Timeout counter counts cycles with in_row != target row.
  - If in_row == target row on a cycle: → HOLD, press_count+1, hold counter loaded with cmd_hold.
  - If the counter reaches TIMEOUT_CYCLES-1 without a match: → GAP with timeout flag set.
- FSM HOLD:
  - Counter decrements every cycle whether or not the row matches. The total HOLD duration is exactly cmd_hold cycles.
  - At counter=1: → GAP.
- FSM GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - On its last cycle, done pulses together with any latched timeout/err_key flag. Flags then clear.
  - → IDLE.
- out_col is combinational: state==HOLD && in_row==target row ? target col : 3'b111.
  - Zero latency relative to in_row, so the scanner sees the column in the same cycle it drives the row.
  - If in_row is not one-hot, or has multiple bits set, it does not match; out_col=111.
- press_count: wraps from 2^CNT_W-1 to 0.
- cmd_valid outside IDLE is ignored. The requester must hold cmd_valid until it sees ready.
- Simultaneous row match and timeout terminal count in WAIT_ROW: the match wins, → HOLD.

Decomposition:
- Package keypad_pkg, shared with the scanner:
  - key code constants KEY_1..KEY_HASH
  - row encodings ROW1..ROW4
  - column encodings COL_L/COL_M/COL_R
  - COL_NONE=3'b111
  - emulator state enum (IDLE, WAIT_ROW, HOLD, GAP)
- Sub-module keypad_key_decode: combinational cmd_key → {valid, row[3:0], col[2:0]}. Reused by the input manager's key-to-flag-bit logic.

Test Plan:
1. Bench scanner rotates in_row 0100→0010→0001→1000, 4 cycles each. Command key=4 (key 5), hold=100 → out_col=010 only in cycles where in_row=0010 inside the 100-cycle HOLD window; done after 100+1000 cycles plus row wait; press_count=1.
2. in_row held at 0100; key=10 (key 0) → no column driven ever; timeout and done pulse together at 10000+1000 cycles after accept; press_count unchanged.
3. key=13 → err_key and done pulse 1000 cycles after accept; out_col stays 111 throughout.
4. hold=0, valid key → done after GAP only; no flags; press_count unchanged.
5. rst asserted mid-HOLD → out_col=111 and cmd_ready=1 the next cycle; no done; a new command is accepted immediately after reset release.
6. Back-to-back commands with cmd_valid held high: 256 successful presses → press_count wraps to 0; cmd_ready never high while busy=1.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad encodings: key codes, row/column drive patterns and the emulator state type.
package keypad_pkg;
    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_4    = 4'd3;
    localparam logic [3:0] KEY_5    = 4'd4;
    localparam logic [3:0] KEY_6    = 4'd5;
    localparam logic [3:0] KEY_7    = 4'd6;
    localparam logic [3:0] KEY_8    = 4'd7;
    localparam logic [3:0] KEY_9    = 4'd8;
    localparam logic [3:0] KEY_STAR = 4'd9;
    localparam logic [3:0] KEY_0    = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [3:0] ROW1 = 4'b0100;
    localparam logic [3:0] ROW2 = 4'b0010;
    localparam logic [3:0] ROW3 = 4'b0001;
    localparam logic [3:0] ROW4 = 4'b1000;

    localparam logic [2:0] COL_L    = 3'b100;
    localparam logic [2:0] COL_M    = 3'b010;
    localparam logic [2:0] COL_R    = 3'b001;
    localparam logic [2:0] COL_NONE = 3'b111;

    typedef enum logic [1:0] {IDLE, WAIT_ROW, HOLD, GAP} emu_state_t;

    typedef struct packed {
        logic [3:0] row;
        logic [2:0] col;
    } key_pos_t;
endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Command handshake between a self-test sequencer and the keypad emulator.
interface keypad_matrix_emulator_if #(parameter int HOLD_W = 20);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;

    modport master (output cmd_valid, cmd_key, cmd_hold, input cmd_ready);
    modport slave  (input cmd_valid, cmd_key, cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_key_decode.sv
// Maps a key code to its matrix position; codes 12..15 decode as invalid.
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [3:0] key,
    output logic       valid,
    output key_pos_t   pos
);
    always_comb begin
        valid   = 1'b1;
        pos.row = 4'b0000;
        pos.col = COL_NONE;
        case (key)
            KEY_1, KEY_2, KEY_3:       pos.row = ROW1;
            KEY_4, KEY_5, KEY_6:       pos.row = ROW2;
            KEY_7, KEY_8, KEY_9:       pos.row = ROW3;
            KEY_STAR, KEY_0, KEY_HASH: pos.row = ROW4;
            default:                   valid   = 1'b0;
        endcase
        case (key)
            KEY_1, KEY_4, KEY_7, KEY_STAR: pos.col = COL_L;
            KEY_2, KEY_5, KEY_8, KEY_0:    pos.col = COL_M;
            KEY_3, KEY_6, KEY_9, KEY_HASH: pos.col = COL_R;
            default:                       pos.col = COL_NONE;
        endcase
    end
endmodule

// File: rtl/keypad_matrix_emulator.sv
// Keypad-side responder: waits for the scanner to drive the commanded key's row,
// then returns that key's column while the row is active for the hold window.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_W         = 20,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int GAP_CYCLES     = 1000,
    parameter int CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               in_row,
    output logic [2:0]               out_col,
    keypad_matrix_emulator_if.slave  cmd,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic                     err_key,
    output logic [CNT_W-1:0]         press_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = $clog2(GAP_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    emu_state_t        state, state_n;
    key_pos_t          dec_pos, tgt_q;
    logic              dec_valid;
    logic [HOLD_W-1:0] hold_q, hcnt;
    logic [TW-1:0]     tcnt;
    logic [GW-1:0]     gcnt;
    logic              to_q, err_q;
    logic              row_hit, gap_last;

    keypad_key_decode u_dec (.key(cmd.cmd_key), .valid(dec_valid), .pos(dec_pos));

    // Exact compare: a non-one-hot or multi-row drive never matches.
    assign row_hit  = (in_row == tgt_q.row);
    assign gap_last = (gcnt == G_LAST);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (cmd.cmd_valid)
                          state_n = (!dec_valid || cmd.cmd_hold == '0) ? GAP : WAIT_ROW;
            WAIT_ROW: if (row_hit)             state_n = HOLD;
                      else if (tcnt == T_LAST) state_n = GAP;
            HOLD:     if (hcnt == HOLD_W'(1))  state_n = GAP;
            GAP:      if (gap_last)            state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state == IDLE);
        busy          = (state != IDLE);
        done          = (state == GAP) && gap_last;
        timeout       = done && to_q;
        err_key       = done && err_q;
        out_col       = (state == HOLD && row_hit) ? tgt_q.col : COL_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tgt_q       <= '{row: 4'b0000, col: COL_NONE};
            hold_q      <= '0;
            hcnt        <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
            to_q        <= 1'b0;
            err_q       <= 1'b0;
            press_count <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (cmd.cmd_valid) begin
                    tgt_q  <= dec_pos;
                    hold_q <= cmd.cmd_hold;
                    err_q  <= !dec_valid;
                    tcnt   <= '0;
                    gcnt   <= '0;
                end
                WAIT_ROW: begin
                    if (row_hit) begin
                        hcnt        <= hold_q;
                        press_count <= press_count + 1'b1;
                    end else if (tcnt == T_LAST) begin
                        to_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                HOLD: hcnt <= hcnt - 1'b1;
                GAP: begin
                    if (gap_last) begin
                        gcnt  <= '0;
                        to_q  <= 1'b0;
                        err_q <= 1'b0;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for the keypad emulator: vector table plus reset and counter-wrap sequences.
module tb_keypad_matrix_emulator;
    import keypad_pkg::*;

    localparam int HOLD_W = 20;
    localparam int T      = 200;
    localparam int G      = 20;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       in_row = ROW1;
    logic [2:0]       out_col;
    logic             busy, done, timeout, err_key;
    logic [CNT_W-1:0] press_count;

    keypad_matrix_emulator_if #(.HOLD_W(HOLD_W)) cif ();

    keypad_matrix_emulator #(
        .HOLD_W(HOLD_W), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_row(in_row), .out_col(out_col), .cmd(cif),
        .busy(busy), .done(done), .timeout(timeout), .err_key(err_key),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Scanner model: rotates rows every 4 cycles, or holds a fixed pattern.
    bit         rot = 1'b1;
    logic [3:0] fixed_row = ROW1;
    int         scan_cnt = 0;
    always @(posedge clk) begin
        #2;
        scan_cnt++;
        if (rot) begin
            case ((scan_cnt / 4) % 4)
                0:       in_row = ROW1;
                1:       in_row = ROW2;
                2:       in_row = ROW3;
                default: in_row = ROW4;
            endcase
        end else begin
            in_row = fixed_row;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [19:0] hold;
        bit          rot;
        logic [3:0]  frow;
        bit          exp_err;
        bit          exp_to;
        bit          exp_press;
        logic [3:0]  exp_row;
        logic [2:0]  exp_col;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        int         n, matchc, done_at, ndone, bad, exp_done;
        logic [7:0] p0, ep;
        logic [2:0] ec;
        bit         elig, got_to, got_err;
        @(negedge clk);
        rot = v.rot;
        fixed_row = v.frow;
        repeat (2) @(negedge clk);
        n = 0;
        while (!cif.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d ready", idx), cif.cmd_ready, 1);
        p0 = press_count;
        cif.cmd_valid = 1'b1;
        cif.cmd_key   = v.key;
        cif.cmd_hold  = v.hold;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        elig = !v.exp_err && v.hold != 0;
        matchc = -1; done_at = -1; ndone = 0; bad = 0; got_to = 0; got_err = 0;
        for (n = 0; n < T + int'(v.hold) + G + 10; n++) begin
            if (n > 0) @(negedge clk);
            ec = (matchc >= 0 && n > matchc && n <= matchc + int'(v.hold) && in_row == v.exp_row)
                 ? v.exp_col : COL_NONE;
            if (out_col !== ec) bad++;
            if (elig && matchc < 0 && n < T && in_row == v.exp_row) matchc = n;
            if (cif.cmd_ready && busy) bad++;
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = n;
                    got_to  = timeout;
                    got_err = err_key;
                end
            end else if (timeout || err_key) begin
                bad++;
            end
            if (done_at >= 0 && n > done_at + 2) break;
        end
        exp_done = !elig ? G - 1 : (matchc >= 0 ? matchc + int'(v.hold) + G : T + G - 1);
        ep = p0 + 8'(v.exp_press);
        check($sformatf("v%0d trace", idx), bad, 0);
        check($sformatf("v%0d ndone", idx), ndone, 1);
        check($sformatf("v%0d done_cycle", idx), done_at, exp_done);
        check($sformatf("v%0d timeout", idx), got_to, v.exp_to);
        check($sformatf("v%0d err_key", idx), got_err, v.exp_err);
        check($sformatf("v%0d press_count", idx), press_count, ep);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int         n, ndone, bad;
        bit         wrapped, seen;
        logic [7:0] p0, prev;

        //          key       hold rot frow  err to press row   col
        vecs[0] = '{KEY_5,    100, 1, ROW1,   0, 0, 1, ROW2, COL_M};
        vecs[1] = '{KEY_0,      5, 0, ROW1,   0, 1, 0, ROW4, COL_M};
        vecs[2] = '{4'd13,     10, 1, ROW1,   1, 0, 0, ROW1, COL_NONE};
        vecs[3] = '{KEY_4,      0, 1, ROW1,   0, 0, 0, ROW2, COL_L};
        vecs[4] = '{KEY_1,      7, 1, ROW1,   0, 0, 1, ROW1, COL_L};
        vecs[5] = '{KEY_HASH,   3, 1, ROW1,   0, 0, 1, ROW4, COL_R};
        vecs[6] = '{KEY_9,      9, 0, ROW3,   0, 0, 1, ROW3, COL_R};
        vecs[7] = '{KEY_5,      5, 0, 4'b0110, 0, 1, 0, ROW2, COL_M};
        vecs[8] = '{4'd15,      0, 1, ROW1,   1, 0, 0, ROW1, COL_NONE};
        vecs[9] = '{KEY_STAR,   2, 0, ROW4,   0, 0, 1, ROW4, COL_L};

        cif.cmd_valid = 1'b0;
        cif.cmd_key   = '0;
        cif.cmd_hold  = '0;

        @(negedge clk);
        check("rst out_col", out_col, COL_NONE);
        check("rst ready", cif.cmd_ready, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst timeout", timeout, 0);
        check("rst err_key", err_key, 0);
        check("rst press_count", press_count, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset in the middle of a hold window.
        @(negedge clk);
        rot = 1'b1;
        cif.cmd_valid = 1'b1;
        cif.cmd_key   = KEY_1;
        cif.cmd_hold  = 50;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        n = 0;
        while (out_col === COL_NONE && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("mid col driven", out_col, COL_L);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst out_col", out_col, COL_NONE);
        check("mid rst ready", cif.cmd_ready, 1);
        check("mid rst busy", busy, 0);
        check("mid rst done", done, 0);
        check("mid rst press_count", press_count, 0);
        rst = 1'b0;
        cif.cmd_valid = 1'b1;
        cif.cmd_key   = KEY_1;
        cif.cmd_hold  = 3;
        @(negedge clk);
        check("post rst accept busy", busy, 1);
        check("post rst accept ready", cif.cmd_ready, 0);
        cif.cmd_valid = 1'b0;
        n = 0; seen = 0;
        while (n < T + G + 50) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("post rst done", seen, 1);
        check("post rst press_count", press_count, 1);

        // Back-to-back presses with cmd_valid held high until the counter wraps.
        @(negedge clk);
        p0 = press_count;
        prev = press_count;
        rot = 1'b1;
        cif.cmd_valid = 1'b1;
        cif.cmd_key   = KEY_2;
        cif.cmd_hold  = 1;
        ndone = 0; bad = 0; wrapped = 0;
        for (n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (cif.cmd_ready && busy) bad++;
            if (prev == 8'hFF && press_count == 8'h00) wrapped = 1;
            prev = press_count;
            if (done) ndone++;
            if (ndone == 256) break;
        end
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        check("wrap presses", ndone, 256);
        check("wrap ready_busy", bad, 0);
        check("wrap seen", wrapped, 1);
        check("wrap press_count", press_count, p0);
        check("wrap idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
